// File: rtl/demux_slot.sv
// One output slot of the registered 1-to-2 demultiplexer.
// Holds a single data word with a valid flag and drains via a valid/ready
// handshake. A load in the same cycle as a drain replaces the word without
// a bubble.
module demux_slot #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic [size-1:0] data_i,
   output logic [size-1:0] data_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            free_o
);

   // The slot can take a new word when it is empty or is being drained now.
   assign free_o = !valid_o || ready_i;

   // Load wins over drain so back-to-back traffic keeps valid_o high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (load_i) begin
         data_o  <= data_i;
         valid_o <= 1'b1;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer.
// Steers one producer stream into one of two registered output slots,
// chosen per transfer by select_i. ready_o only looks at the slot that the
// current select_i points to, so a stalled port never blocks the other one.
// Accepted transfers are counted per destination (wrapping counters).
module demux_1to2_reg #(
   parameter int size  = 32,
   parameter int cnt_w = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [size-1:0]  data_i,
   input  logic             select_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [size-1:0]  data0_o,
   output logic             valid0_o,
   input  logic             ready0_i,
   output logic [size-1:0]  data1_o,
   output logic             valid1_o,
   input  logic             ready1_i,
   output logic [cnt_w-1:0] cnt0_o,
   output logic [cnt_w-1:0] cnt1_o
);

   localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

   logic free0;
   logic free1;
   logic xfer;
   logic load0;
   logic load1;

   // ready_o is a function of select_i and the chosen slot only, never valid_i.
   assign ready_o = !rst_i && (select_i ? free1 : free0);
   assign xfer    = valid_i && ready_o;
   assign load0   = xfer && !select_i;
   assign load1   = xfer && select_i;

   demux_slot #(.size(size)) u_slot0 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load0),
      .data_i  (data_i),
      .data_o  (data0_o),
      .valid_o (valid0_o),
      .ready_i (ready0_i),
      .free_o  (free0)
   );

   demux_slot #(.size(size)) u_slot1 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load1),
      .data_i  (data_i),
      .data_o  (data1_o),
      .valid_o (valid1_o),
      .ready_i (ready1_i),
      .free_o  (free1)
   );

   // Per-destination transfer counters; they wrap rather than saturate.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt0_o <= '0;
         cnt1_o <= '0;
      end else begin
         if (load0) cnt0_o <= cnt0_o + cnt_one;
         if (load1) cnt1_o <= cnt1_o + cnt_one;
      end
   end

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Testbench for demux_1to2_reg: directed scenarios followed by random
// traffic, checked by a scoreboard of per-port expected-word queues.
module tb_demux_1to2_reg;

   localparam int size  = 32;
   localparam int cnt_w = 4;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic [size-1:0]  data_i = '0;
   logic             select_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic [size-1:0]  data0_o;
   logic             valid0_o;
   logic             ready0_i = 1'b1;
   logic [size-1:0]  data1_o;
   logic             valid1_o;
   logic             ready1_i = 1'b1;
   logic [cnt_w-1:0] cnt0_o;
   logic [cnt_w-1:0] cnt1_o;

   int total  = 0;
   int passed = 0;

   // Reference model: each port is a FIFO of words awaiting delivery, plus
   // the last word delivered into that port and a transfer count.
   logic [size-1:0] q0[$];
   logic [size-1:0] q1[$];
   logic [size-1:0] last0 = '0;
   logic [size-1:0] last1 = '0;
   int              n0 = 0;
   int              n1 = 0;

   demux_1to2_reg #(.size(size), .cnt_w(cnt_w)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .select_i (select_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data0_o  (data0_o),
      .valid0_o (valid0_o),
      .ready0_i (ready0_i),
      .data1_o  (data1_o),
      .valid1_o (valid1_o),
      .ready1_i (ready1_i),
      .cnt0_o   (cnt0_o),
      .cnt1_o   (cnt1_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   // Monitor: compares DUT outputs with the model, then advances the model
   // with what the upcoming rising edge will do.
   always @(negedge clk) begin
      logic exp_rdy;
      logic [size-1:0] w;
      exp_rdy = !rst_i && (select_i ? (q1.size() == 0 || ready1_i)
                                    : (q0.size() == 0 || ready0_i));
      chk("ready_o", 64'(ready_o), 64'(exp_rdy));
      chk("valid0", 64'(valid0_o), 64'(q0.size() != 0));
      chk("valid1", 64'(valid1_o), 64'(q1.size() != 0));
      chk("data0", 64'(data0_o), 64'(last0));
      chk("data1", 64'(data1_o), 64'(last1));
      chk("cnt0", 64'(cnt0_o), 64'(n0 % 16));
      chk("cnt1", 64'(cnt1_o), 64'(n1 % 16));
      if (rst_i) begin
         q0.delete(); q1.delete();
         last0 = '0; last1 = '0; n0 = 0; n1 = 0;
      end else begin
         if (valid0_o && ready0_i && q0.size() != 0) begin
            w = q0.pop_front();
            chk("deliver0", 64'(data0_o), 64'(w));
         end
         if (valid1_o && ready1_i && q1.size() != 0) begin
            w = q1.pop_front();
            chk("deliver1", 64'(data1_o), 64'(w));
         end
         if (valid_i && exp_rdy) begin
            if (select_i) begin q1.push_back(data_i); last1 = data_i; n1++; end
            else          begin q0.push_back(data_i); last0 = data_i; n0++; end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word and wait (bounded) until it is accepted.
   task automatic send(input logic [size-1:0] d, input logic s, output int waits);
      logic done;
      done = 1'b0;
      waits = 0;
      valid_i = 1'b1; data_i = d; select_i = s;
      for (int i = 0; i < 64 && !done; i++) begin
         #3;
         if (ready_o) done = 1'b1;
         else waits++;
         step();
      end
      valid_i = 1'b0;
      if (!done) chk("send_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      int w;
      int stalls;
      logic pend;
      step();
      rst_i = 1'b0;

      // Reset mid-operation, with a transfer in flight during reset.
      ready0_i = 1'b0; ready1_i = 1'b0;
      send(32'h11, 1'b0, w);
      send(32'h22, 1'b1, w);
      chk("fill_valid0", 64'(valid0_o), 64'(1));
      chk("fill_valid1", 64'(valid1_o), 64'(1));
      valid_i = 1'b1; data_i = 32'h33; select_i = 1'b0;
      rst_i = 1'b1;
      #3 chk("ready_in_rst", 64'(ready_o), 64'(0));
      step();
      rst_i = 1'b0; valid_i = 1'b0;
      chk("rst_valid0", 64'(valid0_o), 64'(0));
      chk("rst_valid1", 64'(valid1_o), 64'(0));
      chk("rst_data0", 64'(data0_o), 64'(0));
      chk("rst_cnt0", 64'(cnt0_o), 64'(0));
      chk("rst_cnt1", 64'(cnt1_o), 64'(0));

      // Basic routing.
      ready0_i = 1'b1; ready1_i = 1'b1;
      send(32'hA5A5A5A5, 1'b0, w);
      chk("route0", 64'(data0_o), 64'hA5A5A5A5);
      send(32'h5A5A5A5A, 1'b1, w);
      chk("route1", 64'(data1_o), 64'h5A5A5A5A);
      chk("route_cnt0", 64'(cnt0_o), 64'(1));
      chk("route_cnt1", 64'(cnt1_o), 64'(1));
      step();

      // Stall on port 1 does not block port 0.
      ready1_i = 1'b0;
      send(32'h1, 1'b1, w);
      valid_i = 1'b1; data_i = 32'h2; select_i = 1'b1;
      repeat (2) begin
         #3 chk("stall_ready", 64'(ready_o), 64'(0));
         step();
      end
      send(32'h3, 1'b0, w);
      chk("indep_stalls", 64'(w), 64'(0));
      chk("indep_data0", 64'(data0_o), 64'(3));
      chk("held_data1", 64'(data1_o), 64'(1));
      ready1_i = 1'b1;
      step();

      // Full throughput, alternating ports.
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send(size'(i), i[0], w);
         stalls += w;
      end
      chk("thru_stalls", 64'(stalls), 64'(0));
      step();

      // Drain and load in the same cycle.
      ready0_i = 1'b0;
      send(32'h10, 1'b0, w);
      ready0_i = 1'b1;
      send(32'h20, 1'b0, w);
      chk("dl_valid0", 64'(valid0_o), 64'(1));
      chk("dl_data0", 64'(data0_o), 64'h20);
      step();

      // Counter wrap on port 1 (4-bit counters).
      rst_i = 1'b1; step(); rst_i = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         send(size'(100 + i), 1'b1, w);
         if (i == 15) chk("wrap15", 64'(cnt1_o), 64'hF);
         if (i == 16) chk("wrap16", 64'(cnt1_o), 64'h0);
         if (i == 17) chk("wrap17", 64'(cnt1_o), 64'h1);
      end
      chk("wrap_cnt0", 64'(cnt0_o), 64'(0));

      // Random traffic; a stalled word keeps its data, select may change.
      pend = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         ready0_i = ($urandom_range(3) != 0);
         ready1_i = ($urandom_range(3) != 0);
         rst_i    = ($urandom_range(199) == 0);
         if (pend && !rst_i) begin
            if ($urandom_range(3) == 0) select_i = ~select_i;
         end else begin
            valid_i  = ($urandom_range(2) != 0);
            data_i   = $urandom;
            select_i = $urandom_range(1);
         end
         #3 pend = valid_i && !ready_o;
         step();
      end
      rst_i = 1'b0; valid_i = 1'b0; ready0_i = 1'b1; ready1_i = 1'b1;
      repeat (3) step();
      chk("drained0", 64'(q0.size()), 64'(0));
      chk("drained1", 64'(q1.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
